rom_writer: RTL and testbench

//  Word-wide programming engine for the 4x AT28C256 instruction ROM bank read by the fetch stage.

---
 rtl/rom_writer_if.sv | 34 +++
 rtl/rom_writer.sv | 161 ++++++++++++++++
 tb/tb_rom_writer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_writer_if.sv
// Loader-side handshake and ROM bank pins of the rom_writer engine.
// slave = engine view, master = loader/board view (also supplies rom_q from the ROM).
interface rom_writer_if;
  // Handshake: a word transfers on a rising edge where wr_valid and wr_ready are
  // both high; wr_ready is high only while idle, and the word is latched on that edge.
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        wr_err;
  logic        rom_ce_n;
  logic        rom_oe_n;
  logic        rom_we_n;
  logic [12:0] rom_addr;
  logic [31:0] rom_d;
  logic        rom_d_oe;
  logic [31:0] rom_q;
  logic [2:0]  fsm_state;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rom_q,
    output wr_ready, wr_done, wr_err,
    output rom_ce_n, rom_oe_n, rom_we_n, rom_addr, rom_d, rom_d_oe,
    output fsm_state
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rom_q,
    input  wr_ready, wr_done, wr_err,
    input  rom_ce_n, rom_oe_n, rom_we_n, rom_addr, rom_d, rom_d_oe,
    input  fsm_state
  );
endinterface

// File: rtl/rom_writer.sv
// Word-wide AT28C256 x4 programming engine: setup, /WE pulse, hold, write-cycle wait.
// Optional macro ROM_POLL_EN replaces the fixed write-cycle wait with DATA-polling.
module rom_writer #(
  parameter int WE_PULSE_CYC = 4,
  parameter int WC_WAIT_CYC  = 10000
) (
  input  logic         clk,
  input  logic         rst_flag,
  rom_writer_if.slave  bus
);

  localparam int CNT_MAX = (WC_WAIT_CYC > WE_PULSE_CYC) ? WC_WAIT_CYC : WE_PULSE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WE_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WC_WAIT_CYC - 1);

`ifdef ROM_POLL_EN
  localparam logic POLL = 1'b1;
`else
  localparam logic POLL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [12:0]      addr_q;
  logic [31:0]      data_q;
  logic             done_q, err_q;
  logic             done_nx, err_nx;
  logic             ce_n_q, oe_n_q, we_n_q, d_oe_q;
  logic             ce_n_nx, oe_n_nx, we_n_nx, d_oe_nx;
  logic             accept, in_range, latch, poll_hit;

  assign accept   = bus.wr_valid && (state == S_IDLE);
  assign in_range = (bus.wr_addr[31:15] == 17'd0);
  assign latch    = accept && in_range;

`ifdef ROM_POLL_EN
  // DQ7 of each chip reads back the true data bit once its internal write has finished.
  assign poll_hit = (cnt != WAIT_LOAD) &&
                    (bus.rom_q[7]  == data_q[7])  && (bus.rom_q[15] == data_q[15]) &&
                    (bus.rom_q[23] == data_q[23]) && (bus.rom_q[31] == data_q[31]);
`else
  assign poll_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_range) begin
            state_nx = S_SETUP;
          end else begin
            done_nx = 1'b1;
            err_nx  = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_nx = S_PULSE;
        cnt_nx   = PULSE_LOAD;
      end
      S_PULSE: begin
        if (cnt == '0) state_nx = S_HOLD;
        else           cnt_nx   = cnt - 1'b1;
      end
      S_HOLD: begin
        state_nx = S_WAIT;
        cnt_nx   = WAIT_LOAD;
      end
      S_WAIT: begin
        if (poll_hit) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else if (cnt == '0) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
          err_nx   = POLL;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pin levels are decoded from the next state and registered so /WE and /CE never glitch.
  always_comb begin
    ce_n_nx = 1'b1;
    oe_n_nx = 1'b1;
    we_n_nx = 1'b1;
    d_oe_nx = 1'b0;
    case (state_nx)
      S_SETUP, S_HOLD: begin
        ce_n_nx = 1'b0;
        d_oe_nx = 1'b1;
      end
      S_PULSE: begin
        ce_n_nx = 1'b0;
        we_n_nx = 1'b0;
        d_oe_nx = 1'b1;
      end
      S_WAIT: begin
        ce_n_nx = ~POLL;
        oe_n_nx = ~POLL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_flag) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ce_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
      d_oe_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      ce_n_q <= ce_n_nx;
      oe_n_q <= oe_n_nx;
      we_n_q <= we_n_nx;
      d_oe_q <= d_oe_nx;
      if (latch) begin
        addr_q <= bus.wr_addr[14:2];
        data_q <= bus.wr_data;
      end
    end
  end

  assign bus.wr_ready  = (state == S_IDLE);
  assign bus.wr_done   = done_q;
  assign bus.wr_err    = err_q;
  assign bus.rom_ce_n  = ce_n_q;
  assign bus.rom_oe_n  = oe_n_q;
  assign bus.rom_we_n  = we_n_q;
  assign bus.rom_d_oe  = d_oe_q;
  assign bus.rom_addr  = addr_q;
  assign bus.rom_d     = data_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_rom_writer.sv
// Self-checking bench for rom_writer: directed timing scenarios plus a randomized
// run against a cycle-timeline reference model; also builds with ROM_POLL_EN.
module tb_rom_writer;

  localparam int P = 4;
`ifdef ROM_POLL_EN
  localparam int W    = 100;
  localparam bit POLL = 1'b1;
`else
  localparam int W    = 10;
  localparam bit POLL = 1'b0;
`endif
  // Cycle offset from accept to the wr_done pulse for a full-length wait.
  localparam int DONE_REL = P + 3 + W;

  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic d_oe;
    logic ready;
    logic done;
    logic err;
  } pins_t;

  localparam pins_t IDLE_PINS = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, d_oe: 1'b0,
                                  ready: 1'b1, done: 1'b0, err: 1'b0};

  logic        clk = 1'b0;
  logic        rst_flag;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [44:0] exp_q[$];
  logic [12:0] last_waddr;
  bit          poll_match = 1'b0;
  int          poll_t = 0;

  rom_writer_if bus();

  rom_writer #(.WE_PULSE_CYC(P), .WC_WAIT_CYC(W)) dut (
    .clk      (clk),
    .rst_flag (rst_flag),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM read-back model: DQ bits invert the written data until the "write" completes.
  assign bus.rom_q = (poll_match && (cyc >= poll_t + P + 5)) ? bus.rom_d : ~bus.rom_d;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Expected pin levels rel cycles after an accept, straight from the write timeline.
  function automatic pins_t exp_pins(int rel, bit rej, int done_rel, bit done_err);
    pins_t p;
    p = IDLE_PINS;
    if (rej) begin
      if (rel == 1) begin
        p.done = 1'b1;
        p.err  = 1'b1;
      end
      return p;
    end
    if (rel >= 1 && rel <= P + 2) begin
      p.ce_n  = 1'b0;
      p.d_oe  = 1'b1;
      p.ready = 1'b0;
    end
    if (rel >= 2 && rel <= P + 1) p.we_n = 1'b0;
    if (rel >= P + 3 && rel < done_rel) begin
      p.ready = 1'b0;
      if (POLL) begin
        p.ce_n = 1'b0;
        p.oe_n = 1'b0;
      end
    end
    if (rel == done_rel) begin
      p.done = 1'b1;
      p.err  = done_err;
    end
    return p;
  endfunction

  function automatic pins_t obs();
    pins_t p;
    p.ce_n  = bus.rom_ce_n;
    p.we_n  = bus.rom_we_n;
    p.oe_n  = bus.rom_oe_n;
    p.d_oe  = bus.rom_d_oe;
    p.ready = bus.wr_ready;
    p.done  = bus.wr_done;
    p.err   = bus.wr_err;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pins_t got;
    rst_flag = 1'b1;
    tick();
    tick();
    rst_flag = 1'b0;
    @(negedge clk);
    got = obs();
    n_checks++;
    if (got !== IDLE_PINS) begin
      n_fail++;
      $display("FAIL reset_pins: got %b required %b (ce,we,oe,doe,rdy,done,err)", got, IDLE_PINS);
    end
    n_checks++;
    if (bus.rom_addr !== 13'd0 || bus.rom_d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h data %h required 0000 00000000", bus.rom_addr, bus.rom_d);
    end
    @(negedge clk);
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", bus.wr_ready);
    end
  endtask

  task automatic test_write();
    int    t;
    int    rel;
    pins_t got, exp;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 32'h0000_0104;
    bus.wr_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    t = cyc;
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_accept_ready: got %b required 1", bus.wr_ready);
    end
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = $urandom();
    bus.wr_data  = $urandom();
    for (int i = 0; i < DONE_REL + 2; i++) begin
      @(negedge clk);
      rel = cyc - t;
      got = obs();
      exp = exp_pins(rel, 1'b0, DONE_REL, POLL);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL write_pins rel=%0d: got %b required %b", rel, got, exp);
      end
      if (exp.d_oe) begin
        n_checks++;
        if (bus.rom_addr !== 13'h041 || bus.rom_d !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL write_bus rel=%0d: got %h/%h required 041/deadbeef", rel, bus.rom_addr, bus.rom_d);
        end
      end
    end
    n_checks++;
    if (bus.rom_addr !== 13'h041 || bus.rom_d !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_idle_hold: got %h/%h required 041/deadbeef", bus.rom_addr, bus.rom_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, d0, a1, d1;
    int          acc_t[2];
    int          done_t[2];
    int          n_acc, n_done;
    logic        prev_we;
    logic [44:0] e;
    a0 = $urandom() & 32'h0000_7FFF;
    a1 = $urandom() & 32'h0000_7FFF;
    d0 = $urandom();
    d1 = $urandom();
    exp_q.delete();
    exp_q.push_back({a0[14:2], d0});
    exp_q.push_back({a1[14:2], d1});
    acc_t  = '{-1, -1};
    done_t = '{-1, -1};
    n_acc  = 0;
    n_done = 0;
    prev_we = 1'b1;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a0;
    bus.wr_data  = d0;
    for (int i = 0; i < 3 * DONE_REL + 10; i++) begin
      @(negedge clk);
      if (prev_we === 1'b0 && bus.rom_we_n === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_write: got write %h/%h required no write", bus.rom_addr, bus.rom_d);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rom_addr, bus.rom_d} !== e) begin
            n_fail++;
            $display("FAIL b2b_write: got %h/%h required %h/%h", bus.rom_addr, bus.rom_d, e[44:32], e[31:0]);
          end
        end
      end
      prev_we = bus.rom_we_n;
      if (bus.wr_done === 1'b1 && n_done < 2) begin
        done_t[n_done] = cyc;
        n_done++;
      end
      if (bus.wr_valid && bus.wr_ready === 1'b1 && n_acc < 2) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      tick();
      if (n_acc == 1) begin
        bus.wr_addr = a1;
        bus.wr_data = d1;
      end else if (n_acc == 2) begin
        bus.wr_valid = 1'b0;
      end
    end
    last_waddr = a1[14:2];
    n_checks++;
    if (acc_t[1] - acc_t[0] !== DONE_REL) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got offset %0d required %0d", acc_t[1] - acc_t[0], DONE_REL);
    end
    n_checks++;
    if (done_t[0] - acc_t[0] !== DONE_REL) begin
      n_fail++;
      $display("FAIL b2b_first_done: got offset %0d required %0d", done_t[0] - acc_t[0], DONE_REL);
    end
    n_checks++;
    if (done_t[1] - acc_t[0] !== 2 * DONE_REL) begin
      n_fail++;
      $display("FAIL b2b_second_done: got offset %0d required %0d", done_t[1] - acc_t[0], 2 * DONE_REL);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing_writes: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_range();
    int    t;
    pins_t got, exp;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 32'h0000_8000;
    bus.wr_data  = $urandom();
    @(negedge clk);
    t = cyc;
    tick();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = obs();
      exp = exp_pins(cyc - t, 1'b1, DONE_REL, 1'b0);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL range_pins rel=%0d: got %b required %b", cyc - t, got, exp);
      end
    end
    n_checks++;
    if (bus.rom_addr !== last_waddr) begin
      n_fail++;
      $display("FAIL range_addr_kept: got %h required %h", bus.rom_addr, last_waddr);
    end
  endtask

  task automatic test_reset_mid();
    pins_t got;
    bit    seen_done;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ($urandom() & 32'h0000_7FFF) | 32'h0000_0004;
    bus.wr_data  = $urandom() | 32'h1;
    @(negedge clk);
    tick();
    bus.wr_valid = 1'b0;
    tick();
    tick();
    rst_flag = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rom_we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_in_pulse: got we_n %b required 0", bus.rom_we_n);
    end
    tick();
    rst_flag = 1'b0;
    @(negedge clk);
    got = obs();
    n_checks++;
    if (got !== IDLE_PINS) begin
      n_fail++;
      $display("FAIL rstmid_pins: got %b required %b", got, IDLE_PINS);
    end
    n_checks++;
    if (bus.rom_addr !== 13'd0 || bus.rom_d !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_bus: got %h/%h required 0000/00000000", bus.rom_addr, bus.rom_d);
    end
    seen_done = 1'b0;
    for (int i = 0; i < DONE_REL + 5; i++) begin
      @(negedge clk);
      if (bus.wr_done !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got a wr_done pulse required none");
    end
  endtask

  task automatic test_random();
    int          n_words = 25;
    int          n_acc = 0;
    int          t_last = -100000;
    bit          rej_last = 1'b0;
    int          rel;
    logic        prev_we = 1'b1;
    pins_t       got, exp;
    logic [44:0] e;
    exp_q.delete();
    for (int i = 0; i < n_words * (DONE_REL + 6) + 40; i++) begin
      tick();
      if (n_acc < n_words) begin
        bus.wr_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) bus.wr_addr = $urandom() | 32'h0000_8000;
        else                           bus.wr_addr = $urandom() & 32'h0000_7FFF;
        bus.wr_data = $urandom();
      end else begin
        bus.wr_valid = 1'b0;
      end
      @(negedge clk);
      rel = cyc - t_last;
      got = obs();
      exp = exp_pins(rel, rej_last, DONE_REL, POLL);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_pins cyc=%0d rel=%0d: got %b required %b", cyc, rel, got, exp);
      end
      if (prev_we === 1'b0 && bus.rom_we_n === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_write: got write %h/%h required no write", bus.rom_addr, bus.rom_d);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rom_addr, bus.rom_d} !== e) begin
            n_fail++;
            $display("FAIL rand_write: got %h/%h required %h/%h", bus.rom_addr, bus.rom_d, e[44:32], e[31:0]);
          end
        end
      end
      prev_we = bus.rom_we_n;
      if (bus.wr_valid && exp.ready) begin
        t_last   = cyc;
        rej_last = (bus.wr_addr[31:15] != 17'd0);
        if (!rej_last) exp_q.push_back({bus.wr_addr[14:2], bus.wr_data});
        n_acc++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_missing_writes: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_poll();
    int    t;
    pins_t got, exp;
    for (int s = 0; s < 2; s++) begin
      tick();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = $urandom() & 32'h0000_7FFF;
      bus.wr_data  = $urandom();
      @(negedge clk);
      t          = cyc;
      poll_t     = t;
      poll_match = (s == 0);
      tick();
      bus.wr_valid = 1'b0;
      for (int i = 0; i < DONE_REL + 2; i++) begin
        @(negedge clk);
        got = obs();
        if (s == 0) exp = exp_pins(cyc - t, 1'b0, P + 6, 1'b0);
        else        exp = exp_pins(cyc - t, 1'b0, DONE_REL, 1'b1);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL poll%0d_pins rel=%0d: got %b required %b", s, cyc - t, got, exp);
        end
      end
    end
    poll_match = 1'b0;
  endtask

  initial begin
    rst_flag     = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 32'd0;
    bus.wr_data  = 32'd0;
    last_waddr   = 13'd0;
    test_reset();
    test_write();
    test_back_to_back();
    test_range();
    test_reset_mid();
    test_random();
`ifdef ROM_POLL_EN
    test_poll();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
